dsp_issue_stage: RTL
====================

# dsp_issue_stage

Decode/issue stage that sits directly upstream of the ALU in the receiver datapath. It accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal 16×16 register file, forwarding the previous result when needed. It then drives the ALU's combinational opcode/A/B/C/shift inputs from a pipeline register, and captures the ALU result into a handshaked result port with register-file writeback. Branch opcodes (BEZ/BNEZ) are resolved here and emitted as a one-cycle redirect pulse.

## Interface
- Reset: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- Parameters:
  - `N`, 16: operand width.
  - `O`, 8: opcode width.
  - `S`, 5: shift width.
  - `R`, 16: register count (`R0` hardwired to zero).
- Ports:
  - `clk` in 1: clock.
  - `rst` in 1: async active-high reset.
  - `instr_valid` in 1: instruction offered.
  - `instr_ready` out 1: instruction accepted when high with `instr_valid`.
  - `instr` in 32: instruction word.
  - `alu_opcode` out O: to ALU `opcode`.
  - `alu_a`, `alu_b`, `alu_c` out N: to ALU `A`/`B`/`C`.
  - `alu_shift` out S: to ALU `shift`.
  - `alu_out` in N: from ALU `out` (combinational, same cycle).
  - `res_valid` out 1: result held.
  - `res_ready` in 1: consumer takes result.
  - `res_data` out N: result value.
  - `res_rd` out 4: destination register of result.
  - `br_valid` out 1: one-cycle taken-branch pulse.
  - `br_target` out N: branch target.
  - `busy` out 1: EX or result stage occupied.

## Operation
- **Register format** (non-`_I` opcodes): `[31:24]` opcode, `[23:20]` rd, `[19:16]` ra, `[15:12]` rb, `[11:8]` rc, `[7:3]` shift, `[2:0]` reserved. Operands: A=RF[ra], B=RF[rb], C=RF[rc].
- **Immediate format** (`_I` opcodes, BEZ, BNEZ): `[31:24]` opcode, `[23:20]` rd, `[19:16]` ra, `[15:0]` imm16. Operands: A=RF[ra], B=imm16, C=0, shift=0.
- **Accept:** on accept, decoded operands load into the EX register; ALU ports are driven only from the EX register, never from `instr`.
- **EX advance** (`ex_adv`): `ex_valid` and (instruction has no result, or `!res_valid`, or `res_ready`). `instr_ready` = `!ex_valid` or `ex_adv`.
- **On `ex_adv`:**
  - Result opcodes: `res_data`←`alu_out`, `res_rd`←rd, `res_valid`←1, and RF[rd]←`alu_out` on the same edge (suppressed for rd=0).
  - NOP: retires with no result and no write.
  - BEZ/BNEZ: condition is evaluated on the registered A inside this block, never on `alu_out`. If taken, `br_valid`=1 and `br_target`=imm for exactly one cycle. No result, no write.
  - Unknown opcodes: retire as result opcodes, writing whatever the ALU returns.
- **Forwarding:** on an accept while `ex_adv` and EX writes rd≠0, any source equal to EX rd takes `alu_out` instead of RF. R0 reads 0 always.
- **Result stage:** `res_valid` clears on `res_ready` unless refilled the same edge. Data stays stable while `res_valid && !res_ready`.
- **Branches:** there is no squash; upstream sequencer owns redirect.
- **Reset (any time, including mid-instruction):**
  - RF all zero.
  - `ex_valid`, `res_valid`, `br_valid` = 0.
  - `alu_opcode` = `ALU_NOP`.
  - `alu_a`/`alu_b`/`alu_c`/`alu_shift`, `res_data`, `res_rd`, `br_target` = 0.
  - `instr_ready` = 1 after deassertion.
  - In-flight instructions are discarded.

## Timing
- **Latency:** accept at edge n → ALU driven during cycle n+1 → `res_valid` during cycle n+2.
- **Throughput:** one instruction per cycle with `res_ready` held high.
- **Backpressure:** when `res_valid && !res_ready` and EX holds a result opcode, `instr_ready` falls in the same cycle (combinational). Zero bubbles on release.
- **Branch timing:** `br_valid` is asserted in cycle n+2 for a branch accepted at edge n.
- **`busy`:** `ex_valid` | `res_valid`.

## Structure
- **Package `dsp_issue_pkg`** (includes `definitions.v`):
  - Instruction field positions.
  - Functions `is_imm(op)`, `is_branch(op)`, `has_result(op)`.
- **Sub-module `dsp_regfile`:** 16×16, three async read ports, one sync write port, R0 reads zero, async reset clears.

## Test plan
- **Basic issue:** `IADD_I r1,r0,0x0005` → `alu_a`=0, `alu_b`=5 in cycle n+1; `res_valid` at n+2 with `res_data`=0x0005, `res_rd`=1.
- **Forwarding:** back-to-back `IADD_I r1,r0,5` then `IADD_I r2,r1,3` → second shows `alu_a`=5 via forwarding; `res_data`=0x0008, rd=2; one result per cycle.
- **Saturation:** `IADD_I r1,r0,0x7FFF`, then `IADD_I r1,r1,1` with the real ALU → `res_data`=0x7FFF.
- **Backpressure:** `res_ready` low 3 cycles over a stream of 4 adds → `res_data` frozen; `instr_ready` low from the second queued result; all 4 results delivered in order, no loss or duplicate.
- **Branches:**
  - `BEZ r0,0x0040` → `br_valid` one cycle, `br_target`=0x0040, no `res_valid`.
  - `BNEZ r0,0x0040` → no pulse.
  - `BNEZ` on r1=5 → pulse.
- **Reset mid-operation:** `rst` pulsed while EX and result stages are full → outputs at reset values immediately. A subsequent `IADD_I r2,r1,0` returns 0 (RF cleared).

Source files
------------

// File: rtl/dsp_issue_pkg.sv
// Shared definitions for the DSP issue stage: instruction field positions,
// ALU opcode encodings and opcode classification helpers.
package dsp_issue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned SH_W    = 5;
    localparam int unsigned IMM_W   = 16;

    // Instruction field LSB positions
    localparam int unsigned OP_LO   = 24;
    localparam int unsigned RD_LO   = 20;
    localparam int unsigned RA_LO   = 16;
    localparam int unsigned RB_LO   = 12;
    localparam int unsigned RC_LO   = 8;
    localparam int unsigned SH_LO   = 3;
    localparam int unsigned IMM_LO  = 0;

    // ALU opcode encodings
    localparam logic [OP_W-1:0] ALU_NOP = 8'h00;
    localparam logic [OP_W-1:0] ADD     = 8'h01;
    localparam logic [OP_W-1:0] SUB     = 8'h02;
    localparam logic [OP_W-1:0] MAC     = 8'h03;
    localparam logic [OP_W-1:0] SHL     = 8'h04;
    localparam logic [OP_W-1:0] IADD_I  = 8'h11;
    localparam logic [OP_W-1:0] ISUB_I  = 8'h12;
    localparam logic [OP_W-1:0] BEZ     = 8'h20;
    localparam logic [OP_W-1:0] BNEZ    = 8'h21;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == BEZ) || (op == BNEZ);
    endfunction

    // Immediate format: the _I opcodes plus both branches
    function automatic logic is_imm(input logic [OP_W-1:0] op);
        return (op == IADD_I) || (op == ISUB_I) || is_branch(op);
    endfunction

    // Everything except NOP and branches produces a result, unknown opcodes included
    function automatic logic has_result(input logic [OP_W-1:0] op);
        return (op != ALU_NOP) && !is_branch(op);
    endfunction

endpackage

// File: rtl/dsp_regfile.sv
// Register file for the issue stage.
// Ports: clk/rst (async active-high clear), three async read ports
// (ra_*/rd_*), one sync write port (we/wa/wd). R0 reads zero and ignores writes.
module dsp_regfile #(
    parameter int unsigned N  = 16,
    parameter int unsigned R  = 16,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    input  logic [AW-1:0] ra_c,
    output logic [N-1:0]  rd_a,
    output logic [N-1:0]  rd_b,
    output logic [N-1:0]  rd_c,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd
);

    logic [N-1:0] mem [R];

    // Storage with async clear; writes to R0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(R); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd_a = (ra_a == '0) ? '0 : mem[ra_a];
    assign rd_b = (ra_b == '0) ? '0 : mem[ra_b];
    assign rd_c = (ra_c == '0) ? '0 : mem[ra_c];

endmodule

// File: rtl/dsp_issue_stage.sv
// Decode/issue stage in front of the ALU.
// Ports: clk/rst; instr_valid/instr_ready/instr (instruction handshake);
// alu_opcode/alu_a/alu_b/alu_c/alu_shift (registered ALU drive) and alu_out
// (combinational ALU result); res_valid/res_ready/res_data/res_rd (result
// handshake); br_valid/br_target (taken-branch pulse); busy.
module dsp_issue_stage
    import dsp_issue_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned O = 8,
    parameter int unsigned S = 5,
    parameter int unsigned R = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic [O-1:0] alu_opcode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [N-1:0] alu_c,
    output logic [S-1:0] alu_shift,
    input  logic [N-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [3:0]   res_rd,
    output logic         br_valid,
    output logic [N-1:0] br_target,
    output logic         busy
);

    localparam int unsigned AW = REG_AW;

    logic          ex_valid;
    logic [AW-1:0] ex_rd;

    // Decode fields straight off the instruction word
    logic [OP_W-1:0]  op_in;
    logic [AW-1:0]    rd_in;
    logic [AW-1:0]    ra_in;
    logic [AW-1:0]    rb_in;
    logic [AW-1:0]    rc_in;
    logic [SH_W-1:0]  sh_in;
    logic [IMM_W-1:0] imm_in;
    logic             unused_rsvd;

    assign op_in       = instr[OP_LO +: OP_W];
    assign rd_in       = instr[RD_LO +: AW];
    assign ra_in       = instr[RA_LO +: AW];
    assign rb_in       = instr[RB_LO +: AW];
    assign rc_in       = instr[RC_LO +: AW];
    assign sh_in       = instr[SH_LO +: SH_W];
    assign imm_in      = instr[IMM_LO +: IMM_W];
    assign unused_rsvd = ^instr[2:0];

    // Handshake and advance control
    logic ex_has_res;
    logic ex_adv;
    logic accept;
    logic br_taken;
    logic fwd_en;

    assign ex_has_res  = has_result(OP_W'(alu_opcode));
    assign ex_adv      = ex_valid && (!ex_has_res || !res_valid || res_ready);
    assign instr_ready = !ex_valid || ex_adv;
    assign accept      = instr_valid && instr_ready;
    assign busy        = ex_valid || res_valid;

    // Branch condition looks at the registered A operand, not the ALU output
    assign br_taken = is_branch(OP_W'(alu_opcode)) &&
                      ((OP_W'(alu_opcode) == BEZ) == (alu_a == '0));

    // EX result bypass; rd=0 never forwards so R0 stays zero
    assign fwd_en = ex_adv && ex_has_res && (ex_rd != '0);

    logic [N-1:0] rf_a;
    logic [N-1:0] rf_b;
    logic [N-1:0] rf_c;

    dsp_regfile #(
        .N  (N),
        .R  (R),
        .AW (AW)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .ra_a (ra_in),
        .ra_b (rb_in),
        .ra_c (rc_in),
        .rd_a (rf_a),
        .rd_b (rf_b),
        .rd_c (rf_c),
        .we   (ex_adv && ex_has_res),
        .wa   (ex_rd),
        .wd   (alu_out)
    );

    // Operand selection for the instruction being accepted
    logic [N-1:0] src_a_c;
    logic [N-1:0] src_b_c;
    logic [N-1:0] src_c_c;
    logic [N-1:0] next_b_c;
    logic [N-1:0] next_c_c;
    logic [S-1:0] next_sh_c;

    always_comb begin
        src_a_c   = rf_a;
        src_b_c   = rf_b;
        src_c_c   = rf_c;
        next_b_c  = '0;
        next_c_c  = '0;
        next_sh_c = '0;
        if (fwd_en && (ra_in == ex_rd)) src_a_c = alu_out;
        if (fwd_en && (rb_in == ex_rd)) src_b_c = alu_out;
        if (fwd_en && (rc_in == ex_rd)) src_c_c = alu_out;
        if (is_imm(op_in)) begin
            next_b_c = N'(imm_in);
        end else begin
            next_b_c  = src_b_c;
            next_c_c  = src_c_c;
            next_sh_c = S'(sh_in);
        end
    end

    // EX register: sole source of the ALU drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            alu_opcode <= O'(ALU_NOP);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= '0;
            alu_shift  <= '0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_rd      <= rd_in;
            alu_opcode <= O'(op_in);
            alu_a      <= src_a_c;
            alu_b      <= next_b_c;
            alu_c      <= next_c_c;
            alu_shift  <= next_sh_c;
        end else if (ex_adv) begin
            ex_valid   <= 1'b0;
        end
    end

    // Result holding register and branch pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            br_valid  <= 1'b0;
            br_target <= '0;
        end else begin
            if (ex_adv && ex_has_res) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_rd    <= 4'(ex_rd);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            br_valid <= ex_adv && br_taken;
            if (ex_adv && br_taken) begin
                br_target <= alu_b;
            end
        end
    end

endmodule
